// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall sequencer for the 5-stage MIPS pipeline: load-use bubbles, branch
// flushes, variable-latency data-memory handshake with timeout, stall counter.
`timescale 1ns/1ps
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  ex_rt,
  input  logic        ex_memread,
  input  logic        ex_branch_taken,
  input  logic        mem_req,
  input  logic        dmem_ack,
  output logic        dmem_req,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exmem_en,
  output logic        memwb_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        memwb_flush,
  output logic        mem_fault,
  output logic [15:0] stall_cnt
);

  localparam int WW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {RUN, MEM_WAIT, FAULT} state_t;

  state_t        state, state_nxt;
  logic [WW-1:0] wait_cnt, wait_nxt;
  logic          load_use;

  assign load_use = ex_memread && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));

  always_comb begin
    state_nxt   = state;
    wait_nxt    = wait_cnt;
    dmem_req    = 1'b0;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    memwb_flush = 1'b0;
    mem_fault   = 1'b0;
    case (state)
      RUN: begin
        dmem_req = mem_req;
        if (mem_req && !dmem_ack) begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_en     = 1'b0;
          exmem_en    = 1'b0;
          memwb_flush = 1'b1;
          state_nxt   = MEM_WAIT;
          wait_nxt    = '0;
        end else if (ex_branch_taken) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (load_use) begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
        end
      end
      MEM_WAIT: begin
        dmem_req = 1'b1;
        if (!dmem_ack) begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_en     = 1'b0;
          exmem_en    = 1'b0;
          memwb_flush = 1'b1;
          if (wait_cnt == WAIT_LAST) state_nxt = FAULT;
          else                       wait_nxt  = wait_cnt + 1'b1;
        end else begin
          state_nxt = RUN;
        end
      end
      FAULT: begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        memwb_flush = 1'b1;
        mem_fault   = 1'b1;
      end
      default: state_nxt = RUN;
    endcase
    // Reset quiesces every output combinationally, abandoning any request in flight.
    if (rst) begin
      dmem_req    = 1'b0;
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      memwb_flush = 1'b0;
      mem_fault   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      wait_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (!pc_en && (stall_cnt != '1)) stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (MEM_TIMEOUT=4): vector table
// for single-cycle hazard decode, hand sequences for memory wait, timeout, reset.
`timescale 1ns/1ps
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  id_rs = '0, id_rt = '0, ex_rt = '0;
  logic        ex_memread = 1'b0, ex_branch_taken = 1'b0, mem_req = 1'b0, dmem_ack = 1'b0;
  logic        dmem_req, pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_flush, idex_flush, memwb_flush, mem_fault;
  logic [15:0] stall_cnt;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned exp_stall = 0;

  // {dmem_req, pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_fl, idex_fl, memwb_fl}
  localparam logic [8:0] O_RUN = 9'b0_11111_000;
  localparam logic [8:0] O_LU  = 9'b0_00111_010;
  localparam logic [8:0] O_BR  = 9'b0_11111_110;
  localparam logic [8:0] O_MS  = 9'b1_00001_001;
  localparam logic [8:0] O_ACK = 9'b1_11111_000;
  localparam logic [8:0] O_AB  = 9'b1_11111_110;
  localparam logic [8:0] O_ALU = 9'b1_00111_010;
  localparam logic [8:0] O_FLT = 9'b0_00000_001;
  localparam logic [8:0] O_RST = 9'b0_00000_000;

  typedef struct {
    logic [4:0] rs, rt, xrt;
    logic       mr, br, mq, ack;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[10];

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .ex_rt(ex_rt),
    .ex_memread(ex_memread), .ex_branch_taken(ex_branch_taken), .mem_req(mem_req),
    .dmem_ack(dmem_ack), .dmem_req(dmem_req), .pc_en(pc_en), .ifid_en(ifid_en),
    .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .memwb_flush(memwb_flush), .mem_fault(mem_fault),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] outs();
    return {dmem_req, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
            ifid_flush, idex_flush, memwb_flush};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle's inputs after the falling edge, check before the next rising edge.
  task automatic apply(input string nm, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] xrt, input logic mr, input logic br,
                       input logic mq, input logic ack, input logic [8:0] exp,
                       input logic fault);
    @(negedge clk);
    id_rs = rs; id_rt = rt; ex_rt = xrt; ex_memread = mr;
    ex_branch_taken = br; mem_req = mq; dmem_ack = ack;
    #1;
    chk({nm, "_out"}, 32'(outs()), 32'(exp));
    chk({nm, "_fault"}, 32'(mem_fault), 32'(fault));
    chk({nm, "_cnt"}, 32'(stall_cnt), exp_stall);
    if (!exp[7] && exp_stall < 32'hFFFF) exp_stall++;
  endtask

  task automatic do_reset(input string nm);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk({nm, "_out"}, 32'(outs()), 32'(O_RST));
    chk({nm, "_fault"}, 32'(mem_fault), 32'd0);
    chk({nm, "_cnt"}, 32'(stall_cnt), 32'd0);
    @(negedge clk);
    chk({nm, "_hold_cnt"}, 32'(stall_cnt), 32'd0);
    rst = 1'b0;
    exp_stall = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_RUN};
    vecs[1] = '{5'd5, 5'd9, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, O_LU};
    vecs[2] = '{5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, O_RUN};
    vecs[3] = '{5'd3, 5'd7, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, O_LU};
    vecs[4] = '{5'd7, 5'd7, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, O_RUN};
    vecs[5] = '{5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, O_BR};
    vecs[6] = '{5'd5, 5'd1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, O_BR};
    vecs[7] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, O_ACK};
    vecs[8] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, O_AB};
    vecs[9] = '{5'd4, 5'd6, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1, O_ALU};

    #1;
    chk("init_out", 32'(outs()), 32'(O_RST));
    chk("init_cnt", 32'(stall_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_stall = 0;

    for (int i = 0; i < 10; i++)
      apply($sformatf("vec%0d", i), vecs[i].rs, vecs[i].rt, vecs[i].xrt, vecs[i].mr,
            vecs[i].br, vecs[i].mq, vecs[i].ack, vecs[i].exp, 1'b0);
    apply("vec_end", 0, 0, 0, 0, 0, 0, 0, O_RUN, 1'b0);

    // Mid-run reset, then first cycle fully enabled
    do_reset("rst_mid");
    apply("post_rst", 0, 0, 0, 0, 0, 0, 0, O_RUN, 1'b0);

    // Three-wait access: stall three cycles, release in the ack cycle
    apply("m3_run", 0, 0, 0, 0, 0, 1, 0, O_MS, 1'b0);
    apply("m3_w0",  0, 0, 0, 0, 0, 1, 0, O_MS, 1'b0);
    apply("m3_w1",  0, 0, 0, 0, 0, 1, 0, O_MS, 1'b0);
    apply("m3_ack", 0, 0, 0, 0, 0, 1, 1, O_ACK, 1'b0);
    apply("m3_done", 0, 0, 0, 0, 0, 0, 0, O_RUN, 1'b0);
    chk("m3_stall3", 32'(stall_cnt), 32'd3);

    // Memory stall beats branch; branch re-evaluated after release
    apply("mb_run", 0, 0, 0, 0, 1, 1, 0, O_MS, 1'b0);
    apply("mb_ack", 0, 0, 0, 0, 1, 1, 1, O_ACK, 1'b0);
    apply("mb_br",  0, 0, 0, 0, 1, 0, 0, O_BR, 1'b0);

    // Ack in last wait cycle wins over timeout
    apply("late_run", 0, 0, 0, 0, 0, 1, 0, O_MS, 1'b0);
    apply("late_w0",  0, 0, 0, 0, 0, 1, 0, O_MS, 1'b0);
    apply("late_w1",  0, 0, 0, 0, 0, 1, 0, O_MS, 1'b0);
    apply("late_w2",  0, 0, 0, 0, 0, 1, 0, O_MS, 1'b0);
    apply("late_ack", 0, 0, 0, 0, 0, 1, 1, O_ACK, 1'b0);
    apply("late_done", 0, 0, 0, 0, 0, 0, 0, O_RUN, 1'b0);

    // Reset while waiting drops the request at once
    apply("rw_run", 0, 0, 0, 0, 0, 1, 0, O_MS, 1'b0);
    apply("rw_w0",  0, 0, 0, 0, 0, 1, 0, O_MS, 1'b0);
    do_reset("rst_wait");
    mem_req = 1'b0;

    // Timeout: five request cycles, then terminal fault
    apply("to_run", 0, 0, 0, 0, 0, 1, 0, O_MS, 1'b0);
    for (int i = 0; i < 4; i++)
      apply($sformatf("to_w%0d", i), 0, 0, 0, 0, 0, 1, 0, O_MS, 1'b0);
    apply("to_flt0", 0, 0, 0, 0, 0, 1, 0, O_FLT, 1'b1);
    apply("to_flt_ack", 0, 0, 0, 0, 0, 1, 1, O_FLT, 1'b1);
    apply("to_flt_br", 5, 0, 5, 1, 1, 0, 0, O_FLT, 1'b1);

    // Saturation while held in FAULT
    repeat (70000) @(posedge clk);
    @(negedge clk);
    chk("sat_cnt", 32'(stall_cnt), 32'hFFFF);
    chk("sat_fault", 32'(mem_fault), 32'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("sat_nowrap", 32'(stall_cnt), 32'hFFFF);

    do_reset("rst_flt");
    apply("after_flt", 0, 0, 0, 0, 0, 0, 0, O_RUN, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central sequencing controller for the 5-stage pipelined MIPS core. It drives the enable and flush inputs of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. Each cycle it resolves three stall sources:

- load-use hazards that forwarding cannot cover;
- taken branches resolved in EX;
- data-memory accesses with variable latency, completed by a req/ack handshake and guarded by a timeout.

It also keeps a saturating stall-cycle performance counter.

## Interface
Parameters:
- MEM_TIMEOUT, 15, maximum MEM_WAIT cycles without dmem_ack before FAULT; legal range ≥1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- ex_rt  in  5  destination rt of the instruction in EX (ID/EX output).
- ex_memread  in  1  the instruction in EX is a load.
- ex_branch_taken  in  1  branch resolved taken in EX this cycle.
- mem_req  in  1  the instruction in MEM performs a load or store (EX/MEM MemRead|MemWrite).
- dmem_ack  in  1  data memory completes the current access this cycle.
- dmem_req  out  1  request to data memory.
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  pipeline register load enables.
- ifid_flush, idex_flush, memwb_flush  out  1 each  load a bubble (all control bits 0) on the next edge.
- mem_fault  out  1  sticky memory-timeout indication.
- stall_cnt  out  16  saturating count of cycles with pc_en=0.

## Operation
- State machine states: RUN, MEM_WAIT, FAULT. Internal wait_cnt is sized to hold MEM_TIMEOUT-1.
- Outputs are combinational from state and inputs. Defaults: every *_en=1, every flush=0, dmem_req=0, in priority order below. Lower-priority conditions are ignored when a higher one applies.
- Priority 1, memory stall (RUN):
  - mem_req=1 forces dmem_req=1.
  - If dmem_ack=1 in the same cycle: no stall, stay RUN.
  - Otherwise: pc_en, ifid_en, idex_en, exmem_en=0; memwb_flush=1; next state MEM_WAIT with wait_cnt=0.
- MEM_WAIT:
  - dmem_req=1; pc_en, ifid_en, idex_en, exmem_en=0.
  - If dmem_ack=0: memwb_flush=1.
    - If wait_cnt==MEM_TIMEOUT-1: next state FAULT.
    - Otherwise: wait_cnt++.
  - If dmem_ack=1: all enables=1, no flush, next state RUN. The access completes and MEM/WB captures the result.
- Priority 2, taken branch (RUN, no memory stall): ifid_flush=1, idex_flush=1, all enables 1.
- Priority 3, load-use (RUN, no memory stall, no branch):
  - Condition: ex_memread=1, ex_rt≠0, and (ex_rt==id_rs or ex_rt==id_rt).
  - Response: pc_en=0, ifid_en=0, idex_flush=1; exmem_en and memwb_en stay 1.
- FAULT:
  - All *_en=0, memwb_flush=1, dmem_req=0, mem_fault=1.
  - FAULT is terminal; only rst exits it.
- stall_cnt: +1 on each rising edge where pc_en=0 and rst=0; saturates at 16'hFFFF and never wraps.

## Timing
- rst asserted (asynchronous): state=RUN, wait_cnt=0, stall_cnt=0, mem_fault=0.
- While rst=1, outputs are forced to: all *_en=0, all flushes=0, dmem_req=0, mem_fault=0, stall_cnt=0. The first enabled edge is the first rising edge after rst deasserts.
- Reset asserted in MEM_WAIT or FAULT: the request is abandoned immediately (dmem_req drops combinationally).
- Zero-wait access: the dmem_ack cycle equals the request cycle, giving no stall.
- N-wait access: N stall cycles, then pipeline release in the ack cycle. stall_cnt increases by N.
- Timeout: dmem_req is high for 1+MEM_TIMEOUT cycles, then FAULT is entered on the next edge.
  - An ack in the last wait cycle (wait_cnt==MEM_TIMEOUT-1) wins: return to RUN, no fault.
- Load-use bubble lasts exactly 1 cycle. On the next cycle the load has moved to MEM and the hazard condition clears.
- Branch and load-use in the same cycle: branch wins. No pc stall, stall_cnt is unchanged.
- mem_req together with branch or load-use: the memory stall wins and the branch/load-use is re-evaluated once the pipeline releases, because the EX instruction is held.

## Test plan
- Reset: rst=1 mid-run → all enables 0, stall_cnt=0, mem_fault=0. After deassert, first cycle shows all enables 1.
- Load-use: ex_memread=1, ex_rt=5, id_rs=5 → one cycle with pc_en=0, ifid_en=0, idex_flush=1; stall_cnt=1. Repeat with ex_rt=0 → no stall.
- Branch: ex_branch_taken=1 with the load-use condition also true → ifid_flush=idex_flush=1, pc_en=1, stall_cnt unchanged.
- Memory latency: mem_req=1, dmem_ack after 3 cycles → 3 cycles of front-stage enables=0 with memwb_flush=1, release in the ack cycle, stall_cnt=3. Zero-wait ack → no stall.
- Timeout: MEM_TIMEOUT=4, no ack → dmem_req high 5 cycles, then mem_fault=1 and dmem_req=0, held until rst. Ack on the 4th wait cycle → no fault.
- Saturation: hold FAULT for 70000 cycles → stall_cnt=16'hFFFF, no wrap.
